// File: rtl/forward_stall_unit.sv
// Operand bypass selection and load-use stall control for a short in-order pipeline.
// Forwarding is purely combinational; the stall FSM inserts LOAD_LAT bubbles per load-use hazard.
module forward_stall_unit #(
  parameter int DATA_W   = 16,
  parameter int REG_W    = 3,
  parameter int N_RD     = 2,
  parameter int LOAD_LAT = 1,
  parameter int ZERO_REG = 0
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [N_RD*REG_W-1:0]    i_id_rd_reg,
  input  logic [N_RD-1:0]          i_id_rd_valid,
  input  logic [N_RD*DATA_W-1:0]   i_id_rf_data,
  input  logic [REG_W-1:0]         i_ex_wr_reg,
  input  logic                     i_ex_wr_en,
  input  logic                     i_ex_is_load,
  input  logic [REG_W-1:0]         i_em_wr_reg,
  input  logic                     i_em_wr_en,
  input  logic                     i_em_is_load,
  input  logic [DATA_W-1:0]        i_em_alu_data,
  input  logic [REG_W-1:0]         i_mw_wr_reg,
  input  logic                     i_mw_wr_en,
  input  logic [DATA_W-1:0]        i_mw_data,
  input  logic                     i_pipe_hold,
  output logic [N_RD*DATA_W-1:0]   o_fwd_data,
  output logic [N_RD*2-1:0]        o_fwd_sel,
  output logic                     o_stall_id,
  output logic                     o_bubble_ex,
  output logic [15:0]              o_stall_events
);

  localparam int CNT_W = $clog2(LOAD_LAT + 1);

  localparam logic [1:0] SEL_RF = 2'b00;
  localparam logic [1:0] SEL_EM = 2'b01;
  localparam logic [1:0] SEL_MW = 2'b10;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [15:0]      r_stall_events;
  logic             w_count_hazard;
  logic             w_stall_id;
  logic             w_bubble_ex;
  logic [N_RD-1:0]  w_port_hazard;
  logic             w_hazard;

  genvar k;
  generate
    for (k = 0; k < N_RD; k++) begin : g_port
      logic [REG_W-1:0]  w_idx;
      logic              w_not_zero;
      logic              w_hit_ex;
      logic              w_hit_em;
      logic              w_hit_mw;
      logic [1:0]        w_sel;
      logic [DATA_W-1:0] w_data;

      assign w_idx      = i_id_rd_reg[k*REG_W +: REG_W];
      assign w_not_zero = !((ZERO_REG != 0) && (w_idx == '0));
      assign w_hit_ex   = i_id_rd_valid[k] && i_ex_wr_en && (w_idx == i_ex_wr_reg) && w_not_zero;
      assign w_hit_em   = i_id_rd_valid[k] && i_em_wr_en && (w_idx == i_em_wr_reg) && w_not_zero;
      assign w_hit_mw   = i_id_rd_valid[k] && i_mw_wr_en && (w_idx == i_mw_wr_reg) && w_not_zero;

      // A load in EX/MEM has no data yet, so it falls through to the older MEM/WB value or the RF.
      always_comb begin
        w_sel  = SEL_RF;
        w_data = i_id_rf_data[k*DATA_W +: DATA_W];
        if (w_hit_em && !i_em_is_load) begin
          w_sel  = SEL_EM;
          w_data = i_em_alu_data;
        end else if (w_hit_mw) begin
          w_sel  = SEL_MW;
          w_data = i_mw_data;
        end
      end

      assign o_fwd_sel[k*2 +: 2]           = w_sel;
      assign o_fwd_data[k*DATA_W +: DATA_W] = w_data;
      assign w_port_hazard[k]             = w_hit_ex && i_ex_is_load;
    end
  endgenerate

  assign w_hazard = |w_port_hazard;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= RUN;
      r_cnt          <= '0;
      r_stall_events <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_count_hazard && (r_stall_events != 16'hFFFF)) begin
        r_stall_events <= r_stall_events + 16'd1;
      end
    end
  end

  // An external hold freezes everything but still keeps ID frozen; bubbles resume once it releases.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_stall_id     = 1'b0;
    w_bubble_ex    = 1'b0;
    w_count_hazard = 1'b0;
    if (i_rst) begin
      w_state_nxt = RUN;
      w_cnt_nxt   = '0;
    end else if (i_pipe_hold) begin
      w_stall_id = 1'b1;
    end else begin
      case (r_state)
        RUN: begin
          if (w_hazard) begin
            w_stall_id     = 1'b1;
            w_bubble_ex    = 1'b1;
            w_count_hazard = 1'b1;
            if (LOAD_LAT > 1) begin
              w_state_nxt = STALL;
              w_cnt_nxt   = CNT_W'(LOAD_LAT - 1);
            end
          end
        end
        STALL: begin
          w_stall_id  = 1'b1;
          w_bubble_ex = 1'b1;
          w_cnt_nxt   = r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            w_state_nxt = RUN;
          end
        end
        default: begin
          w_state_nxt = RUN;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign o_stall_id     = w_stall_id;
  assign o_bubble_ex    = w_bubble_ex;
  assign o_stall_events = r_stall_events;

endmodule

// File: doc/forward_stall_unit.md
FORWARD_STALL_UNIT -- requirements
Module: forward_stall_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 16: register data width.
REQ-002 SHALL have parameter REG_W, default 3: register-index width.
REQ-003 SHALL have parameter N_RD, default 2: number of ID-stage read ports.
REQ-004 SHALL have parameter LOAD_LAT, default 1, legal 1..7: bubbles inserted per load-use hazard.
REQ-005 SHALL have parameter ZERO_REG, default 0: 1 means register 0 is hard-wired and never forwarded or stalled on.
REQ-006 SHALL use one clock and a synchronous, active-high reset. Ports, one per line (name, direction, width, meaning):
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- id_rd_reg  in  N_RD*REG_W  source indices; port k occupies bits [k*REG_W +: REG_W].
- id_rd_valid  in  N_RD  port k actually reads a register.
- id_rf_data  in  N_RD*DATA_W  register-file read data.
- ex_wr_reg, ex_wr_en, ex_is_load  in  REG_W,1,1  destination of the instruction in EX.
- em_wr_reg, em_wr_en, em_is_load  in  REG_W,1,1  EX/MEM destination.
- em_alu_data  in  DATA_W  EX/MEM ALU result.
- mw_wr_reg, mw_wr_en  in  REG_W,1  MEM/WB destination.
- mw_data  in  DATA_W  MEM/WB writeback value.
- pipe_hold  in  1  external memory stall; the whole pipe is frozen.
- fwd_data  out  N_RD*DATA_W  operand data after bypassing.
- fwd_sel  out  N_RD*2  per port: 00 RF, 01 EM, 10 MW.
- stall_id  out  1  hold PC and IF/ID.
- bubble_ex  out  1  insert a NOP into ID/EX.
- stall_events  out  16  saturating count of load-use hazards detected.

Function
REQ-007 SHALL select the bypass source for each port k independently and combinationally, zero latency.
REQ-008 Port k SHALL match a stage when all of the following hold:
- id_rd_valid[k]=1;
- the stage's wr_en=1;
- the indices are equal;
- not (ZERO_REG=1 and the index is 0).
REQ-009 Bypass priority SHALL be EM match, then MW match, then RF:
- EM with em_is_load=0 gives sel 01 and em_alu_data;
- MW gives sel 10 and mw_data;
- otherwise sel 00 and id_rf_data.
REQ-010 An EM match with em_is_load=1 SHALL NOT select EM; the port SHALL fall back to the MW or RF rule.
REQ-011 A load-use hazard SHALL be flagged when any port matches EX with ex_is_load=1.
REQ-012 The FSM SHALL have states RUN and STALL and a counter cnt of width ceil(log2(LOAD_LAT+1)).
REQ-013 In RUN with a hazard and pipe_hold=0:
- stall_id=1 and bubble_ex=1 in the same cycle;
- if LOAD_LAT>1, next state is STALL with cnt=LOAD_LAT-1;
- otherwise the FSM stays in RUN.
REQ-014 In STALL:
- stall_id=1 and bubble_ex=1;
- cnt decrements each cycle;
- when cnt=1 the next state is RUN;
- hazard inputs are ignored.
REQ-015 While pipe_hold=1:
- the state, cnt and stall_events SHALL hold;
- stall_id=1 and bubble_ex=0;
- fwd_sel and fwd_data stay live.
REQ-016 stall_events SHALL increment by 1 on each RUN-state cycle that has a hazard and pipe_hold=0, and SHALL saturate at 0xFFFF.
REQ-017 A hazard on several ports in the same cycle SHALL count once and insert LOAD_LAT bubbles total.

Reset
REQ-018 With rst=1 at a clock edge, the next state SHALL be: state RUN, cnt 0, stall_events 0.
REQ-019 While rst=1, stall_id and bubble_ex SHALL be 0; fwd_sel and fwd_data remain combinational.
REQ-020 Reset during STALL SHALL abort the stall; no residual bubbles follow reset deassertion.
REQ-021 rst SHALL take priority over pipe_hold.

Verification
REQ-022 EM bypass: port0 reads r3; em_wr_reg=3, em_wr_en=1, em_is_load=0, em_alu_data=0x1234; mw also targets r3 with 0xBEEF -> fwd_sel[1:0]=01 and port0 data 0x1234.
REQ-023 MW bypass and zero register:
- ZERO_REG=1, port1 reads r0, mw_wr_reg=0 -> sel 00 and RF data;
- ZERO_REG=0, same stimulus -> sel 10 and mw_data.
REQ-024 Load-use, LOAD_LAT=3: ex_is_load=1, ex_wr_reg=5, port0 reads r5 -> stall_id=bubble_ex=1 for exactly 3 cycles, then 0; stall_events=1.
REQ-025 Hold during stall: LOAD_LAT=2 with pipe_hold=1 for 4 cycles after the first bubble -> bubble_ex=0 while held, then exactly 1 further bubble.
REQ-026 Dual-port hazard, reset, saturation:
- both ports hit one load -> stall_events increments by 1 only;
- rst in the second STALL cycle -> stall_id=0 the next cycle;
- preload the counter to 0xFFFF by repeated hazards -> it stays 0xFFFF.
